beep_pattern_gen: RTL and testbench

- Output-side counterpart of the button input path. It turns single-cycle event requests into timed, repeating on/off patterns on the buzzer and indicator LED.
- Event sources include countdown expiry and key-press acknowledge.
- Pattern timing runs on the same slow tick enable (CE) that paces the input filtering, so both directions share one time base.
- Sits between the timer control logic and the board buzzer/LED pins.

---
 rtl/beep_pattern_gen_pkg.sv | 12 +
 rtl/beep_phase_cnt.sv | 21 ++
 rtl/beep_pattern_gen.sv | 83 ++++++++
 tb/tb_beep_pattern_gen.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/beep_pattern_gen_pkg.sv
// beep_pattern_gen_pkg: shared state encodings and default tick constants
// for the buzzer/LED pattern generator and the input-side filtering.
package beep_pattern_gen_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } beep_state_e;
    localparam int TICK_HZ       = 100;
    localparam int DEF_ON_TICKS  = 50;
    localparam int DEF_OFF_TICKS = 50;
endpackage

// File: rtl/beep_phase_cnt.sv
// beep_phase_cnt: loadable down counter timing one on/off phase.
// Ports: CLK clock, CLR async active-high reset, CE tick enable,
//        LOAD/LOAD_VAL synchronous load (wins over CE), ZERO count==0.
import beep_pattern_gen_pkg::*;
module beep_phase_cnt #(
    parameter int CNT_BITS = 8
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                CE,
    input  logic                LOAD,
    input  logic [CNT_BITS-1:0] LOAD_VAL,
    output logic                ZERO
);
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    assign ZERO = cnt_q == '0;
    always_comb cnt_d = LOAD ? LOAD_VAL : (CE && !ZERO) ? cnt_q - 1'b1 : cnt_q;
    always_ff @(posedge CLK or posedge CLR)
        if (CLR) cnt_q <= '0;
        else     cnt_q <= cnt_d;
endmodule

// File: rtl/beep_pattern_gen.sv
// beep_pattern_gen: turns START requests into timed repeating beep patterns.
// Ports: CLK, CLR (async active-high), CE phase tick, TONE carrier,
//        START/STOP request pulses, BEEP_NUM beeps per pattern (0 = forever),
//        BUZZ gated tone, LED on-phase, BUSY pattern active, DONE completion pulse.
import beep_pattern_gen_pkg::*;
module beep_pattern_gen #(
    parameter int CNT_BITS  = 8,
    parameter int ON_TICKS  = DEF_ON_TICKS,
    parameter int OFF_TICKS = DEF_OFF_TICKS,
    parameter int NUM_BITS  = 4
) (
    input  logic                CLK,
    input  logic                CLR,
    input  logic                CE,
    input  logic                TONE,
    input  logic                START,
    input  logic                STOP,
    input  logic [NUM_BITS-1:0] BEEP_NUM,
    output logic                BUZZ,
    output logic                LED,
    output logic                BUSY,
    output logic                DONE
);
    localparam logic [CNT_BITS-1:0] ON_LD  = CNT_BITS'(ON_TICKS - 1);
    localparam logic [CNT_BITS-1:0] OFF_LD = CNT_BITS'(OFF_TICKS - 1);
    beep_state_e         state_q, state_d;
    logic [NUM_BITS-1:0] rem_q, rem_d;
    logic                done_q, done_d;
    logic                load, zero;
    logic [CNT_BITS-1:0] load_val;
    beep_phase_cnt #(.CNT_BITS(CNT_BITS)) u_phase (
        .CLK(CLK), .CLR(CLR), .CE(CE), .LOAD(load), .LOAD_VAL(load_val), .ZERO(zero)
    );
    // STOP beats START, START beats any CE-driven transition (incl. completion).
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        done_d   = 1'b0;
        load     = 1'b0;
        load_val = ON_LD;
        if (STOP) begin
            state_d = ST_IDLE;
        end else if (START) begin
            state_d = ST_ON;
            rem_d   = BEEP_NUM;
            load    = 1'b1;
        end else if (CE && zero) begin
            case (state_q)
                ST_ON: begin
                    if (rem_q == NUM_BITS'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d  = ST_OFF;
                        load     = 1'b1;
                        load_val = OFF_LD;
                        // rem==0 means continuous and is never decremented
                        rem_d    = (rem_q != '0) ? rem_q - NUM_BITS'(1) : rem_q;
                    end
                end
                ST_OFF: begin
                    state_d = ST_ON;
                    load    = 1'b1;
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge CLK or posedge CLR)
        if (CLR) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    assign LED  = state_q == ST_ON;
    assign BUSY = state_q != ST_IDLE;
    assign DONE = done_q;
    assign BUZZ = LED & TONE;
endmodule

// File: tb/tb_beep_pattern_gen.sv
// tb_beep_pattern_gen: randomized self-checking bench against a tick-count model.
module tb_beep_pattern_gen;
    localparam int ON = 3, OFF = 2, P = ON + OFF;
    logic CLK = 0, CLR = 0, CE = 0, TONE = 0, START = 0, STOP = 0;
    logic [3:0] BEEP_NUM = 0;
    logic BUZZ, LED, BUSY, DONE;
    int checks = 0, errors = 0;
    int ce_mode = 0, ce_cnt = 0;
    bit tone_rand = 0;
    // model: pattern position is the number of CE ticks since START
    bit m_busy = 0, m_done = 0;
    int m_t = 0, m_n = 0;

    beep_pattern_gen #(.CNT_BITS(8), .ON_TICKS(ON), .OFF_TICKS(OFF), .NUM_BITS(4)) dut (
        .CLK(CLK), .CLR(CLR), .CE(CE), .TONE(TONE), .START(START), .STOP(STOP),
        .BEEP_NUM(BEEP_NUM), .BUZZ(BUZZ), .LED(LED), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            m_busy = 0; m_done = 0; m_t = 0; m_n = 0;
        end else begin
            m_done = 0;
            if (STOP) m_busy = 0;
            else if (START) begin
                m_busy = 1; m_t = 0; m_n = int'(BEEP_NUM);
            end else if (m_busy && CE) begin
                m_t++;
                if (m_n != 0 && m_t == m_n * P - OFF) begin
                    m_busy = 0; m_done = 1;
                end
            end
        end
    end

    function automatic logic exp_led();
        return m_busy && ((m_t % P) < ON);
    endfunction

    task automatic cyc(input logic st, input logic sp, input logic [3:0] n);
        @(negedge CLK);
        START = st; STOP = sp; BEEP_NUM = n;
        CE = (ce_mode == 0) ? (ce_cnt % 4 == 3) : (ce_mode == 1) ? 1'($urandom % 2) : 1'b1;
        ce_cnt++;
        TONE = tone_rand ? 1'($urandom % 2) : ~TONE;
        @(posedge CLK); #1;
        START = 0; STOP = 0;
    endtask

    task automatic test_reset();
        CLR = 1; START = 1'($urandom % 2); STOP = 0; CE = 1; TONE = 1; BEEP_NUM = 4'($urandom);
        #1;
        checks++;
        if ({BUZZ, LED, BUSY, DONE} !== 4'b0) begin
            errors++; $display("FAIL reset got %b exp 0000", {BUZZ, LED, BUSY, DONE});
        end
        repeat (2) @(posedge CLK);
        @(negedge CLK); CLR = 0; START = 0;
        ce_mode = 2; tone_rand = 0;
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        TONE = 1; #1;
        checks++;
        if (LED !== 1'b1 || BUSY !== 1'b1) begin
            errors++; $display("FAIL reset_pre_on got led=%b busy=%b exp 1 1", LED, BUSY);
        end
        #2 CLR = 1;
        #1;
        checks++;
        if ({BUZZ, LED, BUSY, DONE} !== 4'b0) begin
            errors++; $display("FAIL reset_mid_on got %b exp 0000", {BUZZ, LED, BUSY, DONE});
        end
        @(negedge CLK); CLR = 0;
    endtask

    task automatic test_two_beeps();
        int ticks = 0, dones = 0;
        ce_mode = 0; tone_rand = 0;
        cyc(1, 0, 2);
        checks++;
        if (LED !== 1'b1 || BUSY !== 1'b1) begin
            errors++; $display("FAIL two_latency got led=%b busy=%b exp 1 1", LED, BUSY);
        end
        for (int i = 0; i < 60 && BUSY === 1'b1; i++) begin
            cyc(0, 0, 0);
            if (CE) ticks++;
            if (DONE === 1'b1) dones++;
            checks++;
            if ({LED, BUSY, DONE} !== {exp_led(), m_busy, m_done}) begin
                errors++; $display("FAIL two_cycle%0d got %b exp %b", i, {LED, BUSY, DONE}, {exp_led(), m_busy, m_done});
            end
        end
        checks++;
        if (dones != 1 || ticks != 8) begin
            errors++; $display("FAIL two_span got dones=%0d ticks=%0d exp 1 8", dones, ticks);
        end
        cyc(0, 0, 0);
    endtask

    task automatic test_continuous();
        int dones = 0;
        ce_mode = 0;
        cyc(1, 0, 0);
        for (int i = 0; i < 80; i++) begin
            cyc(0, 0, 0);
            if (DONE !== 1'b0) dones++;
            checks++;
            if (LED !== exp_led() || BUSY !== 1'b1) begin
                errors++; $display("FAIL cont_cycle%0d got led=%b busy=%b exp %b 1", i, LED, BUSY, exp_led());
            end
        end
        cyc(0, 1, 0);
        checks++;
        if (LED !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0 || dones != 0) begin
            errors++; $display("FAIL cont_stop got led=%b busy=%b done=%b dones=%0d exp 0 0 0 0", LED, BUSY, DONE, dones);
        end
    endtask

    task automatic test_retrigger();
        int on_ticks = 0, dones = 0;
        bit prev_led;
        ce_mode = 0;
        cyc(1, 0, 3);
        for (int i = 0; i < 40 && !(m_busy && !exp_led()); i++) cyc(0, 0, 0);
        checks++;
        if (BUSY !== 1'b1 || LED !== 1'b0) begin
            errors++; $display("FAIL retrig_off got busy=%b led=%b exp 1 0", BUSY, LED);
        end
        cyc(1, 0, 1);
        checks++;
        if (LED !== 1'b1 || BUSY !== 1'b1) begin
            errors++; $display("FAIL retrig_on got led=%b busy=%b exp 1 1", LED, BUSY);
        end
        for (int i = 0; i < 40 && BUSY === 1'b1; i++) begin
            prev_led = LED;
            cyc(0, 0, 0);
            if (CE && prev_led) on_ticks++;
            if (DONE === 1'b1) dones++;
            checks++;
            if ({LED, BUSY, DONE} !== {exp_led(), m_busy, m_done}) begin
                errors++; $display("FAIL retrig_cycle%0d got %b exp %b", i, {LED, BUSY, DONE}, {exp_led(), m_busy, m_done});
            end
        end
        checks++;
        if (on_ticks != 3 || dones != 1 || BUSY !== 1'b0) begin
            errors++; $display("FAIL retrig_span got on=%0d dones=%0d busy=%b exp 3 1 0", on_ticks, dones, BUSY);
        end
    endtask

    task automatic test_collisions();
        ce_mode = 2;
        cyc(0, 0, 0);
        cyc(1, 1, 2);
        checks++;
        if (BUSY !== 1'b0 || LED !== 1'b0) begin
            errors++; $display("FAIL start_stop got busy=%b led=%b exp 0 0", BUSY, LED);
        end
        cyc(1, 0, 1);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        cyc(1, 0, 2);
        checks++;
        if (BUSY !== 1'b1 || LED !== 1'b1 || DONE !== 1'b0) begin
            errors++; $display("FAIL start_on_done got busy=%b led=%b done=%b exp 1 1 0", BUSY, LED, DONE);
        end
        cyc(0, 1, 0);
    endtask

    task automatic test_buzz();
        int bad = 0, led_cycles = 0;
        ce_mode = 0; tone_rand = 0;
        cyc(1, 0, 2);
        for (int i = 0; i < 60 && BUSY === 1'b1; i++) begin
            if (LED === 1'b1) led_cycles++;
            if (BUZZ !== (exp_led() & TONE)) bad++;
            cyc(0, 0, 0);
        end
        checks++;
        if (bad != 0 || led_cycles == 0) begin
            errors++; $display("FAIL buzz got bad=%0d led_cycles=%0d exp 0 nonzero", bad, led_cycles);
        end
    endtask

    task automatic test_random();
        logic st, sp;
        ce_mode = 1; tone_rand = 1;
        for (int i = 0; i < 400; i++) begin
            st = ($urandom % 12) == 0;
            sp = ($urandom % 30) == 0;
            cyc(st, sp, 4'($urandom % 4));
            checks++;
            if ({LED, BUSY, DONE, BUZZ} !== {exp_led(), m_busy, m_done, exp_led() & TONE}) begin
                errors++; $display("FAIL rand_cycle%0d got %b exp %b", i, {LED, BUSY, DONE, BUZZ}, {exp_led(), m_busy, m_done, exp_led() & TONE});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_two_beeps();
        test_continuous();
        test_retrigger();
        test_collisions();
        test_buzz();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
